// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scanout reads win on active pixel strobes, and two
// drawing requesters share the remaining cycles round-robin with 1-cycle read responses.
module vga_fb_arbiter #(
    parameter int AW = 17,
    parameter int DW = 8,
    parameter bit WRITE_BLANK_ONLY = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic          i_active,
    input  logic [AW-1:0] i_disp_addr,
    output logic [DW-1:0] o_pix_data,
    output logic          o_pix_valid,
    input  logic [1:0]    i_req_valid,
    input  logic [1:0]    i_req_we,
    input  logic [AW-1:0] i_req_addr0,
    input  logic [AW-1:0] i_req_addr1,
    input  logic [DW-1:0] i_req_wdata0,
    input  logic [DW-1:0] i_req_wdata1,
    output logic [1:0]    o_req_ready,
    output logic [1:0]    o_rsp_valid,
    output logic [DW-1:0] o_rsp_data,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_P0, TAG_P1} tag_t;

    tag_t          tag, tag_next;
    logic          last_port;
    logic [DW-1:0] pix_hold;
    logic          disp_slot;
    logic [1:0]    eligible;
    logic [1:0]    grant;

    // Tag register, round-robin pointer and the held scanout pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tag       <= TAG_NONE;
            last_port <= 1'b1;
            pix_hold  <= '0;
        end else begin
            tag <= tag_next;
            if (grant[0])
                last_port <= 1'b0;
            else if (grant[1])
                last_port <= 1'b1;
            if (tag == TAG_DISP)
                pix_hold <= i_mem_rdata;
        end
    end

    // Same-cycle arbitration; a tie goes to the port that did not transfer last
    always_comb begin
        disp_slot = i_pix_stb & i_active;
        for (int n = 0; n < 2; n++)
            eligible[n] = i_req_valid[n] & ~(WRITE_BLANK_ONLY & i_req_we[n] & i_active);
        grant = 2'b00;
        if (!i_rst && !disp_slot) begin
            if (&eligible)
                grant = last_port ? 2'b01 : 2'b10;
            else
                grant = eligible;
        end
    end

    always_comb begin
        if (disp_slot)
            tag_next = TAG_DISP;
        else if (grant[0] && !i_req_we[0])
            tag_next = TAG_P0;
        else if (grant[1] && !i_req_we[1])
            tag_next = TAG_P1;
        else
            tag_next = TAG_NONE;
    end

    // RAM port mux and response outputs; responses are masked while reset is held
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (disp_slot) begin
            o_mem_addr = i_disp_addr;
        end else if (grant[0]) begin
            o_mem_addr  = i_req_addr0;
            o_mem_we    = i_req_we[0];
            o_mem_wdata = i_req_wdata0;
        end else if (grant[1]) begin
            o_mem_addr  = i_req_addr1;
            o_mem_we    = i_req_we[1];
            o_mem_wdata = i_req_wdata1;
        end
        o_req_ready    = grant;
        o_pix_valid    = (tag == TAG_DISP) && !i_rst;
        o_pix_data     = o_pix_valid ? i_mem_rdata : pix_hold;
        o_rsp_valid[0] = (tag == TAG_P0) && !i_rst;
        o_rsp_valid[1] = (tag == TAG_P1) && !i_rst;
        o_rsp_data     = i_mem_rdata;
    end

endmodule
